// File: rtl/uart_tx_arbiter_if.sv
// Producer-side and UART-side byte handshake shared by the UART transmit arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   reqValid;
  logic [8*NUM_REQ-1:0] reqData;
  logic [NUM_REQ-1:0]   reqLast;
  logic [NUM_REQ-1:0]   reqAccept;
  logic [NUM_REQ-1:0]   grant;
  logic                 uartStart;
  logic [7:0]           uartData;
  logic                 uartReady;
  logic [7:0]           timeoutCount;

  modport slave (
    input  reqValid, reqData, reqLast, uartReady,
    output reqAccept, grant, uartStart, uartData, timeoutCount
  );

  modport master (
    output reqValid, reqData, reqLast, uartReady,
    input  reqAccept, grant, uartStart, uartData, timeoutCount
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter that shares one UART transmitter among NUM_REQ
// byte-stream producers, with a watchdog that reclaims the UART from a stalled owner.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              sclk,
  input  logic              rstn,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND  = 2'd1;
  localparam logic [1:0] GUARD = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] ownerIdx;
  logic [IDX_W-1:0] lastOwner;
  logic             lastFlag;
  logic             guardCnt;
  logic [WD_W-1:0]  wdCount;

  logic [IDX_W-1:0] pickIdx;
  logic             pickFound;
  logic             ownerValid;
  logic [7:0]       ownerData;
  logic             ownerLast;
  logic             wdExpired;

  // Requester index k positions after base, wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  function automatic logic [NUM_REQ-1:0] oneHot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Search starts just after the previous owner, so the previous owner comes last.
  always_comb begin
    // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
    pickIdx   = lastOwner;
    pickFound = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!pickFound && bus.reqValid[nextIdx(lastOwner, k)]) begin
        pickIdx   = nextIdx(lastOwner, k);
        pickFound = 1'b1;
      end
    end
  end

  assign ownerValid = bus.reqValid[ownerIdx];
  assign ownerData  = bus.reqData[{ownerIdx, 3'b000} +: 8];
  assign ownerLast  = bus.reqLast[ownerIdx];
  assign wdExpired  = (wdCount == WD_LAST);

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      ownerIdx         <= '0;
      lastOwner        <= IDX_W'(NUM_REQ - 1);
      lastFlag         <= 1'b0;
      guardCnt         <= 1'b0;
      wdCount          <= '0;
      bus.grant        <= '0;
      bus.reqAccept    <= '0;
      bus.uartStart    <= 1'b0;
      bus.uartData     <= 8'h00;
      bus.timeoutCount <= 8'h00;
    end else begin
      bus.uartStart <= 1'b0;
      bus.reqAccept <= '0;

      case (state)
        IDLE: begin
          if (pickFound) begin
            bus.grant <= oneHot(pickIdx);
            ownerIdx  <= pickIdx;
            wdCount   <= '0;
            state     <= SEND;
          end
        end

        SEND: begin
          if (wdExpired) begin
            bus.grant <= '0;
            lastOwner <= ownerIdx;
            if (bus.timeoutCount != 8'hFF) bus.timeoutCount <= bus.timeoutCount + 8'd1;
            state     <= IDLE;
          end else if (ownerValid && bus.uartReady) begin
            bus.uartStart <= 1'b1;
            bus.uartData  <= ownerData;
            bus.reqAccept <= bus.grant;
            lastFlag      <= ownerLast;
            wdCount       <= '0;
            guardCnt      <= 1'b0;
            state         <= GUARD;
          end else begin
            wdCount <= wdCount + WD_W'(1);
          end
        end

        // Two blind cycles give the UART time to drop ready after the start pulse.
        GUARD: begin
          if (guardCnt) state <= WAIT;
          else          guardCnt <= 1'b1;
        end

        WAIT: begin
          if (wdExpired) begin
            bus.grant <= '0;
            lastOwner <= ownerIdx;
            if (bus.timeoutCount != 8'hFF) bus.timeoutCount <= bus.timeoutCount + 8'd1;
            state     <= IDLE;
          end else begin
            wdCount <= wdCount + WD_W'(1);
            if (bus.uartReady) begin
              if (lastFlag) begin
                bus.grant <= '0;
                lastOwner <= ownerIdx;
                state     <= IDLE;
              end else begin
                state <= SEND;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: producer queues, a UART busy model and a byte
// scoreboard, with a short watchdog so stall and saturation cases run quickly.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ  = 3;
  localparam int TIMEOUT  = 100;
  localparam int UART_BSY = 10;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } srcT;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } expT;

  logic sclk;
  logic rstn;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .sclk(sclk),
    .rstn(rstn),
    .bus (bus)
  );

  int  vectors     = 0;
  int  miscompares = 0;

  srcT srcQ[NUM_REQ][$];
  expT expQ[$];
  logic [NUM_REQ-1:0] expGrantQ[$];
  int  acceptCnt[NUM_REQ];
  bit  stuck = 1'b0;
  int  busy  = 0;
  logic [NUM_REQ-1:0] prevGrant = '0;

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Producers: present the head of each queue; retire it on the accept pulse.
  always @(negedge sclk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.reqAccept[i] === 1'b1) begin
        acceptCnt[i]++;
        if (srcQ[i].size() > 0) void'(srcQ[i].pop_front());
      end
      if (srcQ[i].size() > 0) begin
        bus.reqValid[i]       = 1'b1;
        bus.reqData[8*i +: 8] = srcQ[i][0].data;
        bus.reqLast[i]        = srcQ[i][0].last;
      end else begin
        bus.reqValid[i]       = 1'b0;
        bus.reqData[8*i +: 8] = 8'h00;
        bus.reqLast[i]        = 1'b0;
      end
    end
  end

  // Scoreboard, grant-order monitor and UART busy model share one process so the
  // ready value checked at a start is the one the DUT sampled.
  always @(negedge sclk) begin
    expT e;
    logic [NUM_REQ-1:0] g;
    if (bus.uartStart === 1'b1) begin
      check("startWhileBusy", {31'd0, bus.uartReady}, 32'd1);
      check("startPending", {31'd0, expQ.size() > 0}, 32'd1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("uartData", {24'd0, bus.uartData}, {24'd0, e.data});
        check("reqAcceptOwner", {29'd0, bus.reqAccept}, 32'(1 << e.idx));
        check("grantOwner", {29'd0, bus.grant}, 32'(1 << e.idx));
      end
      busy = UART_BSY;
    end else if (busy > 0) begin
      busy--;
    end
    bus.uartReady = !stuck && (busy == 0);

    if (bus.grant !== '0 && prevGrant === '0 && expGrantQ.size() > 0) begin
      g = expGrantQ.pop_front();
      check("grantOrder", {29'd0, bus.grant}, {29'd0, g});
    end
    prevGrant = bus.grant;
  end

  task automatic waitGrant(input logic [NUM_REQ-1:0] want, input int budget, input string tag);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge sclk);
      if (bus.grant === want) hit = 1'b1;
    end
    check(tag, {31'd0, hit}, 32'd1);
  endtask

  task automatic waitStart(input int budget, input string tag);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge sclk);
      if (bus.uartStart === 1'b1) hit = 1'b1;
    end
    check(tag, {31'd0, hit}, 32'd1);
  endtask

  // Waits until every expected byte has gone out and the grant has been released.
  task automatic waitDone(input int budget, input string tag);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge sclk);
      if (expQ.size() == 0 && bus.grant === '0) hit = 1'b1;
    end
    check(tag, {31'd0, hit}, 32'd1);
  endtask

  // Counts negedges, from the current one, on which some grant is held.
  task automatic countHeld(output int n);
    n = 0;
    while (bus.grant !== '0 && n < 400) begin
      n++;
      @(negedge sclk);
    end
  endtask

  task automatic clearAll();
    for (int i = 0; i < NUM_REQ; i++) begin
      srcQ[i].delete();
      acceptCnt[i] = 0;
    end
    expQ.delete();
    expGrantQ.delete();
  endtask

  task automatic pushByte(input int idx, input logic [7:0] data, input logic last, input bit expectOut);
    srcQ[idx].push_back('{data: data, last: last});
    if (expectOut) expQ.push_back('{idx: idx, data: data});
  endtask

  initial begin
    int held;
    int expCount;

    rstn = 1'b0;
    clearAll();
    repeat (3) @(negedge sclk);
    check("rstGrant", {29'd0, bus.grant}, 32'd0);
    check("rstAccept", {29'd0, bus.reqAccept}, 32'd0);
    check("rstStart", {31'd0, bus.uartStart}, 32'd0);
    check("rstData", {24'd0, bus.uartData}, 32'd0);
    check("rstTimeouts", {24'd0, bus.timeoutCount}, 32'd0);
    rstn = 1'b1;

    // 1: one three-byte packet from requester 0.
    expGrantQ.push_back(3'b001);
    pushByte(0, 8'hA5, 1'b0, 1'b1);
    pushByte(0, 8'h5A, 1'b0, 1'b1);
    pushByte(0, 8'hFF, 1'b1, 1'b1);
    waitGrant(3'b001, 20, "t1Grant");
    waitDone(500, "t1Done");
    check("t1Accepts", acceptCnt[0], 32'd3);

    // 2: all three requesters valid straight out of reset.
    rstn = 1'b0;
    @(negedge sclk);
    clearAll();
    for (int i = 0; i < NUM_REQ; i++) begin
      pushByte(i, 8'(8'h10 * (i + 1)), 1'b0, 1'b1);
      pushByte(i, 8'(8'h10 * (i + 1) + 1), 1'b1, 1'b1);
      expGrantQ.push_back(3'(1 << i));
    end
    @(negedge sclk);
    rstn = 1'b1;
    waitDone(1000, "t2Done");
    for (int i = 0; i < NUM_REQ; i++) check("t2Accepts", acceptCnt[i], 32'd2);

    // 3: requester 0 streams single-byte packets while requester 2 competes.
    pushByte(0, 8'h01, 1'b1, 1'b0);
    pushByte(0, 8'h02, 1'b1, 1'b0);
    pushByte(0, 8'h03, 1'b1, 1'b0);
    pushByte(0, 8'h04, 1'b1, 1'b0);
    pushByte(2, 8'h81, 1'b1, 1'b0);
    pushByte(2, 8'h82, 1'b1, 1'b0);
    expQ.push_back('{idx: 0, data: 8'h01});
    expQ.push_back('{idx: 2, data: 8'h81});
    expQ.push_back('{idx: 0, data: 8'h02});
    expQ.push_back('{idx: 2, data: 8'h82});
    expQ.push_back('{idx: 0, data: 8'h03});
    expQ.push_back('{idx: 0, data: 8'h04});
    expGrantQ.push_back(3'b001);
    expGrantQ.push_back(3'b100);
    expGrantQ.push_back(3'b001);
    expGrantQ.push_back(3'b100);
    expGrantQ.push_back(3'b001);
    expGrantQ.push_back(3'b001);
    waitDone(2000, "t3Done");
    check("t3GrantsSeen", expGrantQ.size(), 32'd0);

    // 4: requester 1 stalls after one non-final byte; watchdog hands over to requester 2.
    expGrantQ.push_back(3'b010);
    expGrantQ.push_back(3'b100);
    pushByte(1, 8'h3C, 1'b0, 1'b1);
    waitStart(50, "t4Start");
    pushByte(2, 8'hC3, 1'b1, 1'b1);
    countHeld(held);
    check("t4StallCycles", held, 32'd102);
    check("t4Timeouts", {24'd0, bus.timeoutCount}, 32'd1);
    waitGrant(3'b100, 5, "t4Handover");
    waitDone(500, "t4Done");

    // 5: UART never ready; every grant of requester 0 times out, counter saturates.
    stuck = 1'b1;
    repeat (UART_BSY + 2) @(negedge sclk);
    pushByte(0, 8'h77, 1'b1, 1'b1);
    for (int it = 1; it <= 300; it++) begin
      waitGrant(3'b001, 20, "t5Grant");
      countHeld(held);
      check("t5StallCycles", held, 32'(TIMEOUT));
      expCount = (it + 1 > 255) ? 255 : it + 1;
      check("t5Timeouts", {24'd0, bus.timeoutCount}, 32'(expCount));
    end
    check("t5NoStart", expQ.size(), 32'd1);
    stuck = 1'b0;
    waitDone(500, "t5Done");

    // 6: reset during the WAIT phase of a requester-2 packet.
    expGrantQ.push_back(3'b100);
    pushByte(2, 8'h11, 1'b0, 1'b1);
    pushByte(2, 8'h22, 1'b1, 1'b1);
    waitStart(50, "t6Start");
    repeat (4) @(negedge sclk);
    #2;
    rstn = 1'b0;
    #1;
    check("t6Grant", {29'd0, bus.grant}, 32'd0);
    check("t6Accept", {29'd0, bus.reqAccept}, 32'd0);
    check("t6Start", {31'd0, bus.uartStart}, 32'd0);
    check("t6Data", {24'd0, bus.uartData}, 32'd0);
    check("t6Timeouts", {24'd0, bus.timeoutCount}, 32'd0);
    clearAll();
    pushByte(0, 8'h44, 1'b1, 1'b1);
    pushByte(2, 8'h55, 1'b1, 1'b1);
    expGrantQ.push_back(3'b001);
    expGrantQ.push_back(3'b100);
    repeat (2) @(negedge sclk);
    rstn = 1'b1;
    waitGrant(3'b001, 5, "t6FirstGrant");
    waitDone(1000, "t6Done");
    check("t6GrantsSeen", expGrantQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
